// File: rtl/gpr_hilo_file_if.sv
`default_nettype none
// ============================================================================
// Module   : gpr_hilo_file_if
// Purpose  : Write-back bus, GPR read ports and HI/LO read port of the
//            OpenMIPS register file.
// Revision : 1.0 - initial release
// ============================================================================
interface gpr_hilo_file_if;
    logic        wb_wreg;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    // Pipeline side: drives write-back and read requests, consumes read data.
    modport master (
        output wb_wreg, wb_waddr, wb_wdata, wb_whilo, wb_hi, wb_lo,
        output re1, raddr1, re2, raddr2,
        input  rdata1, rdata2, hi_o, lo_o
    );

    modport slave (
        input  wb_wreg, wb_waddr, wb_wdata, wb_whilo, wb_hi, wb_lo,
        input  re1, raddr1, re2, raddr2,
        output rdata1, rdata2, hi_o, lo_o
    );
endinterface
`default_nettype wire

// File: rtl/gpr_hilo_file.sv
`default_nettype none
// ============================================================================
// Module   : gpr_hilo_file
// Purpose  : 32x32 GPR file plus HI/LO pair with same-cycle write-to-read
//            bypass for the ID/EX stages.
// Revision : 1.0 - initial release
// ============================================================================
module gpr_hilo_file (
    input  wire logic       clk,
    input  wire logic       rst,
    gpr_hilo_file_if.slave  bus
);
    localparam logic [4:0] c_ZERO_ADDR = 5'd0;

    // r0 is not stored; index 0 never reaches the array on a read.
    logic [31:0] r_gpr [1:31];
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                r_gpr[i] <= '0;
            end
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (bus.wb_wreg && (bus.wb_waddr != c_ZERO_ADDR)) begin
                r_gpr[bus.wb_waddr] <= bus.wb_wdata;
            end
            if (bus.wb_whilo) begin
                r_hi <= bus.wb_hi;
                r_lo <= bus.wb_lo;
            end
        end
    end

    function automatic logic [31:0] f_read (
        input logic        rst_v,
        input logic        re,
        input logic [4:0]  addr,
        input logic        wreg,
        input logic [4:0]  waddr,
        input logic [31:0] wdata,
        input logic [31:0] stored
    );
        logic [31:0] v;
        v = '0;
        if (rst_v || (addr == c_ZERO_ADDR) || !re) begin
            v = '0;
        end else if (wreg && (waddr == addr)) begin
            v = wdata;
        end else begin
            v = stored;
        end
        return v;
    endfunction

    logic [31:0] w_stored1;
    logic [31:0] w_stored2;

    always_comb begin
        w_stored1 = '0;
        w_stored2 = '0;
        if (bus.raddr1 != c_ZERO_ADDR) begin
            w_stored1 = r_gpr[bus.raddr1];
        end
        if (bus.raddr2 != c_ZERO_ADDR) begin
            w_stored2 = r_gpr[bus.raddr2];
        end
    end

    assign bus.rdata1 = f_read(rst, bus.re1, bus.raddr1, bus.wb_wreg,
                               bus.wb_waddr, bus.wb_wdata, w_stored1);
    assign bus.rdata2 = f_read(rst, bus.re2, bus.raddr2, bus.wb_wreg,
                               bus.wb_waddr, bus.wb_wdata, w_stored2);

    assign bus.hi_o = rst ? '0 : (bus.wb_whilo ? bus.wb_hi : r_hi);
    assign bus.lo_o = rst ? '0 : (bus.wb_whilo ? bus.wb_lo : r_lo);
endmodule
`default_nettype wire

// File: tb/tb_gpr_hilo_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpr_hilo_file
// Purpose  : Scoreboard bench for gpr_hilo_file: directed scenarios then
//            randomized traffic against an array-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpr_hilo_file;
    logic clk;
    logic rst;

    gpr_hilo_file_if bus ();

    gpr_hilo_file dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] hi;
        logic [31:0] lo;
        string       tag;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;

    logic [31:0] m_gpr [32];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    function automatic logic [31:0] model_read(input logic rs, input logic re,
                                               input logic [4:0] a, input logic wr,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (rs || a == 5'd0 || !re) return 32'd0;
        if (wr && wa == a) return wd;
        return m_gpr[a];
    endfunction

    // Drive one cycle of inputs, queue the expected outputs, then advance the model.
    task automatic cyc(input logic rs, input logic wr, input logic [4:0] wa,
                       input logic [31:0] wd, input logic whl, input logic [31:0] h,
                       input logic [31:0] l, input logic e1, input logic [4:0] a1,
                       input logic e2, input logic [4:0] a2, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = rs;
        bus.wb_wreg  = wr;
        bus.wb_waddr = wa;
        bus.wb_wdata = wd;
        bus.wb_whilo = whl;
        bus.wb_hi    = h;
        bus.wb_lo    = l;
        bus.re1      = e1;
        bus.raddr1   = a1;
        bus.re2      = e2;
        bus.raddr2   = a2;
        e.r1  = model_read(rs, e1, a1, wr, wa, wd);
        e.r2  = model_read(rs, e2, a2, wr, wa, wd);
        e.hi  = rs ? 32'd0 : (whl ? h : m_hi);
        e.lo  = rs ? 32'd0 : (whl ? l : m_lo);
        e.tag = tag;
        q.push_back(e);
        if (rs) begin
            for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
            m_hi = 32'd0;
            m_lo = 32'd0;
        end else begin
            if (wr && wa != 5'd0) m_gpr[wa] = wd;
            if (whl) begin
                m_hi = h;
                m_lo = l;
            end
        end
    endtask

    task automatic chk(input string tag, input string what,
                       input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s %s got=%h want=%h", tag, what, got, want);
        end
    endtask

    // Monitor: outputs are combinational, so every cycle presents a response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.tag, "rdata1", bus.rdata1, e.r1);
                chk(e.tag, "rdata2", bus.rdata2, e.r2);
                chk(e.tag, "hi_o",   bus.hi_o,   e.hi);
                chk(e.tag, "lo_o",   bus.lo_o,   e.lo);
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        rst = 1'b1;
        bus.wb_wreg = 1'b0; bus.wb_waddr = '0; bus.wb_wdata = '0;
        bus.wb_whilo = 1'b0; bus.wb_hi = '0; bus.wb_lo = '0;
        bus.re1 = 1'b0; bus.raddr1 = '0; bus.re2 = 1'b0; bus.raddr2 = '0;

        cyc(1, 0, 0, 0, 0, 0, 0, 1, 5, 1, 6, "reset");
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 5, 1, 6, "reset");

        cyc(0, 1, 5, 32'hDEADBEEF, 1, 32'd1, 32'd2, 1, 5, 0, 0, "rst_clear_wr");
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, "rst_clear_rst");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 5, 1, 5, "rst_clear_rd");

        cyc(0, 1, 7, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, "wr_rd_wr");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 7, "wr_rd_en");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 7, 1, 7, "wr_rd_dis");

        cyc(0, 1, 9, 32'h11, 0, 0, 0, 0, 0, 0, 0, "bypass_pre");
        cyc(0, 1, 9, 32'hAA, 0, 0, 0, 1, 9, 1, 9, "bypass_same");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 9, "bypass_after");

        cyc(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 1, 0, "r0_wr");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, "r0_rd");

        cyc(0, 1, 3, 32'h3, 1, 32'hCAFE0000, 32'h0000BEEF, 1, 3, 0, 0, "hilo_wr");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 7, "hilo_rd");

        cyc(0, 1, 4, 32'h1234, 0, 0, 0, 0, 0, 0, 0, "collide_pre");
        cyc(1, 1, 4, 32'h44, 0, 0, 0, 1, 4, 1, 4, "collide_rst");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 4, "collide_rd");

        for (int n = 0; n < 600; n++) begin
            logic        rs, wr, whl, e1, e2;
            logic [4:0]  wa, a1, a2;
            logic [31:0] wd, h, l;
            rs  = ($urandom_range(0, 39) == 0);
            wr  = ($urandom_range(0, 1) == 1);
            whl = ($urandom_range(0, 3) == 0);
            wa  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wd  = $urandom;
            h   = $urandom;
            l   = $urandom;
            e1  = ($urandom_range(0, 3) != 0);
            e2  = ($urandom_range(0, 3) != 0);
            a1  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 7));
            a2  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            cyc(rs, wr, wa, wd, whl, h, l, e1, a1, e2, a2, "random");
        end

        for (int t = 0; t < 10 && q.size() > 0; t++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
